// File: rtl/muldiv_issue_ctrl.sv
// Execute-stage issue/writeback controller for the M-extension mul_div unit.
// Optional 1-entry result cache enabled by defining MULDIV_RESULT_CACHE_EN.
package muldiv_issue_ctrl_pkg;
    localparam int unsigned XLEN_WIDTH = 32;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_type;

    typedef struct packed {
        alu_op_type            op;
        logic [XLEN_WIDTH-1:0] rs1;
        logic [XLEN_WIDTH-1:0] rs2;
    } md_req_t;
endpackage

module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RD_WIDTH       = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  alu_op_type            req_op,
    input  logic [XLEN_WIDTH-1:0] req_rs1,
    input  logic [XLEN_WIDTH-1:0] req_rs2,
    input  logic [RD_WIDTH-1:0]   req_rd,
    input  logic                  flush,
    output logic                  stall_o,
    output logic                  unit_start,
    output alu_op_type            unit_operation,
    output logic [XLEN_WIDTH-1:0] unit_operand1,
    output logic [XLEN_WIDTH-1:0] unit_operand2,
    input  logic [XLEN_WIDTH-1:0] unit_result,
    input  logic                  unit_ready,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [RD_WIDTH-1:0]   wb_rd,
    output logic [XLEN_WIDTH-1:0] wb_data,
    output logic                  timeout_err
);
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    md_req_t               r_req;
    logic [RD_WIDTH-1:0]   r_rd;
    logic [XLEN_WIDTH-1:0] r_data;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_start;
    logic                  r_timeout_err;

    md_req_t               w_req_in;
    logic                  w_is_md;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_hit;
    logic [XLEN_WIDTH-1:0] w_hit_data;

    assign w_req_in = '{op: req_op, rs1: req_rs1, rs2: req_rs2};
    assign w_is_md  = req_valid &&
                      (req_op inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});

`ifdef MULDIV_RESULT_CACHE_EN
    // Single-entry memo of the last normally completed operation
    logic                  r_cache_vld;
    md_req_t               r_cache_key;
    logic [XLEN_WIDTH-1:0] r_cache_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_vld <= 1'b0;
            r_cache_key <= '0;
            r_cache_res <= '0;
        end else if (w_capture) begin
            r_cache_vld <= 1'b1;
            r_cache_key <= r_req;
            r_cache_res <= unit_result;
        end
    end

    assign w_hit      = r_cache_vld && (r_cache_key == w_req_in);
    assign w_hit_data = r_cache_res;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        stall_o     = 1'b0;
        wb_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_o = w_is_md && !flush;
                if (w_is_md && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_hit ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall_o     = 1'b1;
                w_state_nxt = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else if (unit_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                stall_o  = !wb_ready;
                wb_valid = !flush;
                if (flush || wb_ready) w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                stall_o = 1'b1;
                if (unit_ready) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand latch, result capture and watchdog counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req         <= '{op: ALU_MUL, rs1: '0, rs2: '0};
            r_rd          <= '0;
            r_data        <= '0;
            r_cnt         <= '0;
            r_start       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start       <= (w_state_nxt == S_ISSUE);
            r_timeout_err <= w_timeout;
            if (w_accept) begin
                r_req <= w_req_in;
                r_rd  <= req_rd;
                if (w_hit) r_data <= w_hit_data;
            end
            if (w_capture)      r_data <= unit_result;
            else if (w_timeout) r_data <= '0;
            if ((w_state_nxt == S_WAIT  && r_state != S_WAIT) ||
                (w_state_nxt == S_DRAIN && r_state != S_DRAIN)) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT || r_state == S_DRAIN) && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign unit_start     = r_start;
    assign unit_operation = r_req.op;
    assign unit_operand1  = r_req.rs1;
    assign unit_operand2  = r_req.rs2;
    assign wb_rd          = r_rd;
    assign wb_data        = r_data;
    assign timeout_err    = r_timeout_err;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a behavioural mul_div of programmable latency.
// Cache expectations follow MULDIV_RESULT_CACHE_EN.
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    alu_op_type  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall_o, unit_start, wb_valid, wb_ready, timeout_err;
    alu_op_type  unit_operation;
    logic [31:0] unit_operand1, unit_operand2, unit_result, wb_data;
    logic        unit_ready;
    logic [4:0]  wb_rd;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int n_tmo = 0;
    int lat = 4;
    bit never_ready = 1'b0;

    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_res;

    always #5 clk = ~clk;

    muldiv_issue_ctrl #(.TIMEOUT_CYCLES(64), .RD_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
        .stall_o(stall_o), .unit_start(unit_start), .unit_operation(unit_operation),
        .unit_operand1(unit_operand1), .unit_operand2(unit_operand2),
        .unit_result(unit_result), .unit_ready(unit_ready), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] md_calc(alu_op_type op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_MUL:  return a * b;
            ALU_DIV:  if (b == 0) return '1;
                      else if (a == 32'h8000_0000 && b == '1) return a;
                      else return $signed(a) / $signed(b);
            ALU_DIVU: return (b == 0) ? '1 : a / b;
            ALU_REM:  if (b == 0) return a;
                      else if (a == 32'h8000_0000 && b == '1) return '0;
                      else return $signed(a) % $signed(b);
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return '0;
        endcase
    endfunction

    // mul_div model: ready drops on start and rises lat cycles after the start cycle
    always @(posedge clk) begin
        if (reset) begin
            unit_ready  <= 1'b0;
            unit_result <= '0;
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            m_res       <= '0;
        end else if (unit_start) begin
            unit_ready <= 1'b0;
            m_busy     <= 1'b1;
            m_cnt      <= 1;
            m_res      <= md_calc(unit_operation, unit_operand1, unit_operand2);
        end else if (m_busy && !never_ready) begin
            if (m_cnt >= lat - 1) begin
                unit_ready  <= 1'b1;
                unit_result <= m_res;
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (unit_start)  n_start <= n_start + 1;
        if (timeout_err) n_tmo   <= n_tmo + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input alu_op_type op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_rd    = rd;
    endtask

    // Step cycles until wb_valid, bounded by max; n = cycles since the accept cycle
    task automatic wait_wb(input int start_n, input int max, output int n);
        n = start_n;
        while (!wb_valid && n < max) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int s0;
        int t0;
        reset = 1'b1; req_valid = 1'b0; req_op = ALU_ADD; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; flush = 1'b0; wb_ready = 1'b0;
        repeat (2) cyc();
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_start", 32'(unit_start), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_op", 32'(unit_operation), 32'(ALU_MUL));
        reset = 1'b0;
        cyc();

        // Non-M op and flushed M-op in IDLE: neither stalls nor issues
        drive(ALU_ADD, 32'd1, 32'd2, 5'd1);
        #1 chk("nonmd_stall", 32'(stall_o), 32'd0);
        cyc();
        drive(ALU_MUL, 32'd2, 32'd2, 5'd1);
        flush = 1'b1;
        #1 chk("idle_flush_stall", 32'(stall_o), 32'd0);
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        #1 chk("idle_flush_start", 32'(unit_start), 32'd0);
        cyc();

        // MUL 7*6, latency 4
        lat = 4; wb_ready = 1'b1; s0 = n_start;
        drive(ALU_MUL, 32'd7, 32'd6, 5'd5);
        #1 chk("mul_accept_stall", 32'(stall_o), 32'd1);
        cyc();
        chk("mul_start", 32'(unit_start), 32'd1);
        chk("mul_op", 32'(unit_operation), 32'(ALU_MUL));
        chk("mul_opnd1", unit_operand1, 32'd7);
        chk("mul_opnd2", unit_operand2, 32'd6);
        wait_wb(1, 40, n);
        chk("mul_latency", 32'(n), 32'd6);
        chk("mul_data", wb_data, 32'd42);
        chk("mul_rd", 32'(wb_rd), 32'd5);
        chk("mul_hs_stall", 32'(stall_o), 32'd0);
        cyc();
        req_valid = 1'b0;
        #1 chk("mul_wbv_drop", 32'(wb_valid), 32'd0);
        chk("mul_nstart", 32'(n_start - s0), 32'd1);

        // DIV then REM back to back, latency 3
        cyc();
        lat = 3; s0 = n_start;
        drive(ALU_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9);
        wait_wb(0, 40, n);
        chk("div_latency", 32'(n), 32'd5);
        chk("div_data", wb_data, 32'hFFFF_FFFA);
        chk("div_rd", 32'(wb_rd), 32'd9);
        cyc();
        drive(ALU_REM, 32'hFFFF_FFEC, 32'd3, 5'd10);
        #1 chk("rem_accept_stall", 32'(stall_o), 32'd1);
        wait_wb(0, 40, n);
        chk("rem_latency", 32'(n), 32'd5);
        chk("rem_data", wb_data, 32'hFFFF_FFFE);
        chk("rem_rd", 32'(wb_rd), 32'd10);
        chk("divrem_nstart", 32'(n_start - s0), 32'd2);
        cyc();
        req_valid = 1'b0;
        cyc();

        // Flush in the third WAIT cycle, latency 8
        lat = 8; s0 = n_start;
        drive(ALU_MUL, 32'd11, 32'd13, 5'd3);
        cyc(); cyc(); cyc(); cyc();
        flush = 1'b1;
        #1 chk("fl_wait_wbv", 32'(wb_valid), 32'd0);
        chk("fl_wait_stall", 32'(stall_o), 32'd1);
        cyc();
        flush = 1'b0;
        drive(ALU_MUL, 32'd3, 32'd5, 5'd4);
        for (int i = 0; i < 5; i++) begin
            #1 chk("fl_drain_stall", 32'(stall_o), 32'd1);
            chk("fl_drain_wbv", 32'(wb_valid), 32'd0);
            cyc();
        end
        chk("fl_idle_start", 32'(unit_start), 32'd0);
        chk("fl_nstart", 32'(n_start - s0), 32'd1);
        chk("fl_accept_stall", 32'(stall_o), 32'd1);
        cyc();
        chk("fl_reissue_start", 32'(unit_start), 32'd1);
        chk("fl_reissue_opnd1", unit_operand1, 32'd3);
        wait_wb(1, 40, n);
        chk("fl_latency", 32'(n), 32'd10);
        chk("fl_data", wb_data, 32'd15);
        chk("fl_rd", 32'(wb_rd), 32'd4);
        cyc();
        req_valid = 1'b0;
        cyc();

        // Writeback back-pressure for 5 cycles, latency 2
        lat = 2; wb_ready = 1'b0; s0 = n_start;
        drive(ALU_MUL, 32'd100, 32'd200, 5'd7);
        wait_wb(0, 40, n);
        chk("bp_latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wbv", 32'(wb_valid), 32'd1);
            chk("bp_data", wb_data, 32'd20000);
            chk("bp_rd", 32'(wb_rd), 32'd7);
            chk("bp_stall", 32'(stall_o), 32'd1);
            cyc();
        end
        chk("bp_nstart", 32'(n_start - s0), 32'd1);
        wb_ready = 1'b1;
        #1 chk("bp_hs_stall", 32'(stall_o), 32'd0);
        cyc();
        req_valid = 1'b0;
        #1 chk("bp_wbv_drop", 32'(wb_valid), 32'd0);
        cyc();

        // Unit never responds: watchdog after 64 WAIT cycles
        never_ready = 1'b1; t0 = n_tmo;
        drive(ALU_DIVU, 32'd1, 32'd1, 5'd2);
        cyc();
        chk("tmo_tmo_early", 32'(timeout_err), 32'd0);
        wait_wb(1, 200, n);
        chk("tmo_latency", 32'(n), 32'd66);
        chk("tmo_pulse", 32'(timeout_err), 32'd1);
        chk("tmo_data", wb_data, 32'd0);
        chk("tmo_rd", 32'(wb_rd), 32'd2);
        cyc();
        req_valid = 1'b0; never_ready = 1'b0;
        #1 chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
        chk("tmo_idle_stall", 32'(stall_o), 32'd0);
        chk("tmo_npulse", 32'(n_tmo - t0), 32'd1);
        cyc();

        // MUL 5*9 twice back to back
        lat = 3; s0 = n_start;
        drive(ALU_MUL, 32'd5, 32'd9, 5'd6);
        wait_wb(0, 40, n);
        chk("c1_latency", 32'(n), 32'd5);
        chk("c1_data", wb_data, 32'd45);
        cyc();
        drive(ALU_MUL, 32'd5, 32'd9, 5'd8);
        #1 chk("c2_accept_stall", 32'(stall_o), 32'd1);
        wait_wb(0, 40, n);
`ifdef MULDIV_RESULT_CACHE_EN
        chk("c2_latency", 32'(n), 32'd1);
        chk("c2_nstart", 32'(n_start - s0), 32'd1);
`else
        chk("c2_latency", 32'(n), 32'd5);
        chk("c2_nstart", 32'(n_start - s0), 32'd2);
`endif
        chk("c2_data", wb_data, 32'd45);
        chk("c2_rd", 32'(wb_rd), 32'd8);
        cyc();
        req_valid = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
